muldiv_sequencer: RTL

Multi-cycle controller that computes 32x32 unsigned multiply (64-bit HI/LO) and unsigned divide by sequencing the execute-stage ALU one operation per cycle: shift-add for multiply, restoring division for divide. While busy it takes ownership of the ALU through a mux in the execute stage, and the hazard unit stalls the pipeline. Results are held in HI/LO until the next start.

---
 rtl/muldiv_sequencer_pkg.sv | 13 +
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared widths and execute-stage ALU opcodes used by the multiply/divide sequencer.
// The ALU lives in the execute stage. SLT there is an unsigned compare.
package muldiv_sequencer_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   localparam logic [3:0] EXE_NO_OPERATION = 4'd0;
   localparam logic [3:0] EXE_ADD          = 4'd1;
   localparam logic [3:0] EXE_SUB          = 4'd2;
   localparam logic [3:0] EXE_SLT          = 4'd3;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller that borrows the execute-stage ALU one operation per cycle.
// Multiply uses shift-add. Divide uses restoring division. Results are held in hi/lo until the next start.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH_P = WIDTH,
   parameter int CNT_W_P = CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               op,
   input  logic [WIDTH_P-1:0] src_a,
   input  logic [WIDTH_P-1:0] src_b,
   output logic               busy,
   output logic               done,
   output logic [WIDTH_P-1:0] hi,
   output logic [WIDTH_P-1:0] lo,
   output logic               alu_own,
   output logic [WIDTH_P-1:0] alu_val1,
   output logic [WIDTH_P-1:0] alu_val2,
   output logic [4:0]         alu_shamt,
   output logic [3:0]         alu_ctrl,
   input  logic [WIDTH_P-1:0] alu_result
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MUL_STEP  = 3'd1,
      MUL_CARRY = 3'd2,
      DIV_CMP   = 3'd3,
      DIV_SUB   = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t             state, state_next;
   logic [WIDTH_P-1:0] hi_next, lo_next;
   logic [WIDTH_P-1:0] mcand, mcand_next;   // multiplicand, or divisor during DIVU
   logic [WIDTH_P-1:0] sum, sum_next;
   logic [CNT_W_P-1:0] cnt, cnt_next;
   logic               step_done;
   logic               carry;
   logic [WIDTH_P-1:0] rs;
   logic               ob;

   // Partial remainder shifted left by one. ob is the bit that falls off the top.
   assign rs = {hi[WIDTH_P-2:0], lo[WIDTH_P-1]};
   assign ob = hi[WIDTH_P-1];

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign alu_shamt = 5'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         sum   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         hi    <= hi_next;
         lo    <= lo_next;
         mcand <= mcand_next;
         sum   <= sum_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      hi_next    = hi;
      lo_next    = lo;
      mcand_next = mcand;
      sum_next   = sum;
      cnt_next   = cnt;
      step_done  = 1'b0;
      carry      = 1'b0;
      alu_own    = 1'b0;
      alu_val1   = '0;
      alu_val2   = '0;
      alu_ctrl   = EXE_NO_OPERATION;

      case (state)
         IDLE: begin
            if (start) begin
               cnt_next = CNT_W_P'(WIDTH_P - 1);
               if (!op) begin
                  hi_next    = '0;
                  lo_next    = src_b;
                  mcand_next = src_a;
                  state_next = MUL_STEP;
               end else if (src_b != '0) begin
                  hi_next    = '0;
                  lo_next    = src_a;
                  mcand_next = src_b;
                  state_next = DIV_CMP;
               end else begin
                  hi_next    = src_a;
                  lo_next    = '1;
                  state_next = DONE;
               end
            end
         end
         MUL_STEP: begin
            alu_own  = 1'b1;
            alu_ctrl = EXE_ADD;
            alu_val1 = hi;
            alu_val2 = mcand;
            if (lo[0]) begin
               sum_next   = alu_result;
               state_next = MUL_CARRY;
            end else begin
               hi_next   = {1'b0, hi[WIDTH_P-1:1]};
               lo_next   = {hi[0], lo[WIDTH_P-1:1]};
               step_done = 1'b1;
            end
         end
         MUL_CARRY: begin
            // An unsigned add wrapped exactly when the sum is below one of its addends.
            alu_own   = 1'b1;
            alu_ctrl  = EXE_SLT;
            alu_val1  = sum;
            alu_val2  = hi;
            carry     = alu_result[0];
            hi_next   = {carry, sum[WIDTH_P-1:1]};
            lo_next   = {sum[0], lo[WIDTH_P-1:1]};
            step_done = 1'b1;
         end
         DIV_CMP: begin
            alu_own  = 1'b1;
            alu_ctrl = EXE_SLT;
            alu_val1 = rs;
            alu_val2 = mcand;
            if (!ob && alu_result[0]) begin
               hi_next   = rs;
               lo_next   = {lo[WIDTH_P-2:0], 1'b0};
               step_done = 1'b1;
            end else begin
               state_next = DIV_SUB;
            end
         end
         DIV_SUB: begin
            // When ob is set, the true remainder is 2^W + rs. The wrapped difference is still exact.
            alu_own   = 1'b1;
            alu_ctrl  = EXE_SUB;
            alu_val1  = rs;
            alu_val2  = mcand;
            hi_next   = alu_result;
            lo_next   = {lo[WIDTH_P-2:0], 1'b1};
            step_done = 1'b1;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (step_done) begin
         if (cnt == '0) begin
            state_next = DONE;
         end else begin
            cnt_next   = cnt - 1'b1;
            state_next = (state == MUL_STEP || state == MUL_CARRY) ? MUL_STEP : DIV_CMP;
         end
      end
   end

endmodule
